// File: rtl/reg_serializer.sv
// reg_serializer
//   Parallel-in, serial-out read side of the datapath register. A word is
//   accepted through a ready/load handshake, then shifted out MSB first with
//   each bit held for BIT_PERIOD clocks. ser_valid frames the data bits and
//   ser_done pulses for one cycle after the last bit period.
//
// Ports
//   clock      in   system clock, all state updates on posedge
//   ser_reset  in   asynchronous active-high reset, forces IDLE
//   ser_in     in   [DATA_WIDTH] parallel word to send
//   ser_load   in   load request, honoured only while ser_ready=1
//   ser_ready  out  high in IDLE
//   ser_busy   out  high in SHIFT and DONE
//   ser_out    out  current serial bit, MSB first (0 outside SHIFT)
//   ser_valid  out  high while ser_out carries a data bit
//   ser_done   out  one-cycle pulse after the final bit period
module reg_serializer #(
    parameter int DATA_WIDTH = 11,
    parameter int BIT_PERIOD = 4
) (
    input  logic                  clock,
    input  logic                  ser_reset,
    input  logic [DATA_WIDTH-1:0] ser_in,
    input  logic                  ser_load,
    output logic                  ser_ready,
    output logic                  ser_busy,
    output logic                  ser_out,
    output logic                  ser_valid,
    output logic                  ser_done
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam int PW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [PW-1:0] PER_LAST = PW'(BIT_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] w_shreg_nxt;
    logic [BW-1:0]         r_bit_cnt;
    logic [BW-1:0]         w_bit_cnt_nxt;
    logic [PW-1:0]         r_per_cnt;
    logic [PW-1:0]         w_per_cnt_nxt;

    always_ff @(posedge clock or posedge ser_reset) begin
        if (ser_reset) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_per_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_per_cnt <= w_per_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_per_cnt_nxt = r_per_cnt;
        case (r_state)
            S_IDLE: begin
                if (ser_load) begin
                    w_shreg_nxt   = ser_in;
                    w_bit_cnt_nxt = BIT_LAST;
                    w_per_cnt_nxt = '0;
                    w_state_nxt   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // With BIT_PERIOD=1 PER_LAST is 0, so every SHIFT cycle is terminal.
                if (r_per_cnt == PER_LAST) begin
                    w_per_cnt_nxt = '0;
                    if (r_bit_cnt != '0) begin
                        w_shreg_nxt   = {r_shreg[DATA_WIDTH-2:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt - BW'(1);
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_per_cnt_nxt = r_per_cnt + PW'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decode registered state only; no input-to-output paths.
    always_comb begin
        ser_ready = (r_state == S_IDLE);
        ser_busy  = (r_state == S_SHIFT) || (r_state == S_DONE);
        ser_valid = (r_state == S_SHIFT);
        ser_out   = (r_state == S_SHIFT) && r_shreg[DATA_WIDTH-1];
        ser_done  = (r_state == S_DONE);
    end

endmodule

// File: tb/tb_reg_serializer.sv
module tb_reg_serializer;

    logic        clock;
    logic        ser_reset;
    logic [10:0] ser_in;
    logic        ser_load;
    logic        ser_ready, ser_busy, ser_out, ser_valid, ser_done;

    logic [10:0] ser_in1;
    logic        ser_load1;
    logic        ser_ready1, ser_busy1, ser_out1, ser_valid1, ser_done1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    reg_serializer #(.DATA_WIDTH(11), .BIT_PERIOD(4)) dut (
        .clock(clock), .ser_reset(ser_reset), .ser_in(ser_in), .ser_load(ser_load),
        .ser_ready(ser_ready), .ser_busy(ser_busy), .ser_out(ser_out),
        .ser_valid(ser_valid), .ser_done(ser_done)
    );

    reg_serializer #(.DATA_WIDTH(11), .BIT_PERIOD(1)) dut1 (
        .clock(clock), .ser_reset(ser_reset), .ser_in(ser_in1), .ser_load(ser_load1),
        .ser_ready(ser_ready1), .ser_busy(ser_busy1), .ser_out(ser_out1),
        .ser_valid(ser_valid1), .ser_done(ser_done1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, ser_ready, 1'b1);
        chk({tag, "_busy"},  ser_busy,  1'b0);
        chk({tag, "_valid"}, ser_valid, 1'b0);
        chk({tag, "_out"},   ser_out,   1'b0);
        chk({tag, "_done"},  ser_done,  1'b0);
    endtask

    // Caller has driven ser_in and ser_load=1; the first tick here is the
    // acceptance edge. Bit i (MSB=0) is expected for cycles 4i..4i+3.
    task automatic check_word(input logic [10:0] word, input string tag,
                              input bit keep_load, input bit disturb,
                              output int t_acc);
        for (int c = 0; c < 44; c++) begin
            tick();
            if (c == 0) begin
                t_acc = cyc;
                if (!keep_load) ser_load = 1'b0;
            end
            chk({tag, "_valid"}, ser_valid, 1'b1);
            chk({tag, "_ready"}, ser_ready, 1'b0);
            chk({tag, "_busy"},  ser_busy,  1'b1);
            chk({tag, "_done"},  ser_done,  1'b0);
            chk($sformatf("%s_bit%0d", tag, c / 4), ser_out, word[10 - c / 4]);
            if (disturb) begin
                ser_in   = 11'($urandom);
                ser_load = (c % 3 == 1);
            end
        end
        if (disturb) ser_load = 1'b0;
        tick();
        chk({tag, "_done_pulse"}, ser_done,  1'b1);
        chk({tag, "_done_valid"}, ser_valid, 1'b0);
        chk({tag, "_done_out"},   ser_out,   1'b0);
        chk({tag, "_done_ready"}, ser_ready, 1'b0);
        chk({tag, "_done_busy"},  ser_busy,  1'b1);
        tick();
        chk({tag, "_ready_back"}, ser_ready, 1'b1);
        chk({tag, "_done_low"},   ser_done,  1'b0);
        chk({tag, "_valid_low"},  ser_valid, 1'b0);
    endtask

    initial begin
        int t0, t1;
        logic [10:0] exp1;

        ser_reset = 1'b1;
        ser_in    = '0;
        ser_load  = 1'b0;
        ser_in1   = '0;
        ser_load1 = 1'b0;
        #12;
        ser_reset = 1'b0;

        // Reset state held over idle cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle("idle");
        end

        // Basic word 101_0011_0110
        ser_in   = 11'h536;
        ser_load = 1'b1;
        check_word(11'h536, "w536", 1'b0, 1'b0, t0);

        // Loads and ser_in changes during SHIFT are ignored
        ser_in   = 11'h7FF;
        ser_load = 1'b1;
        check_word(11'h7FF, "w7ff", 1'b0, 1'b1, t0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("no_second");
        end

        // Load held high: back-to-back words
        ser_in   = 11'h001;
        ser_load = 1'b1;
        check_word(11'h001, "b2b_a", 1'b1, 1'b0, t0);
        ser_in = 11'h400;
        check_word(11'h400, "b2b_b", 1'b0, 1'b0, t1);
        chk_int("b2b_spacing", t1 - t0, 46);

        // Asynchronous reset mid-word, during bit 5 of 11'h2AA
        ser_in   = 11'h2AA;
        ser_load = 1'b1;
        for (int c = 0; c < 22; c++) begin
            tick();
            if (c == 0) ser_load = 1'b0;
        end
        chk("pre_rst_valid", ser_valid, 1'b1);
        chk("pre_rst_bit5",  ser_out,   1'b1);
        #2;
        ser_reset = 1'b1;
        #1;
        chk_idle("async_rst");
        @(posedge clock);
        #3;
        chk_idle("rst_held");
        ser_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("post_rst");
        end
        ser_in   = 11'h155;
        ser_load = 1'b1;
        check_word(11'h155, "w155", 1'b0, 1'b0, t0);

        // BIT_PERIOD=1 instance
        exp1      = 11'b100_1100_0011;
        ser_in1   = 11'h4C3;
        ser_load1 = 1'b1;
        for (int c = 0; c < 11; c++) begin
            tick();
            if (c == 0) ser_load1 = 1'b0;
            chk("bp1_valid", ser_valid1, 1'b1);
            chk($sformatf("bp1_bit%0d", c), ser_out1, exp1[10 - c]);
        end
        tick();
        chk("bp1_done",       ser_done1,  1'b1);
        chk("bp1_done_valid", ser_valid1, 1'b0);
        chk("bp1_done_busy",  ser_busy1,  1'b1);
        tick();
        chk("bp1_ready",      ser_ready1, 1'b1);
        chk("bp1_done_low",   ser_done1,  1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
